// File: rtl/counter_sequencer.sv
// Command-driven 8-bit event counter: start/stop/pause control, a prescaler,
// one-shot or periodic terminal count against a programmable limit, and a tick.
module counter_sequencer #(
   parameter int WIDTH = 8,
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [WIDTH-1:0] count,
   output logic [1:0]       state,
   output logic             tick,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      OP_NOP           = 3'd0,
      OP_LOAD_LIMIT    = 3'd1,
      OP_LOAD_PRESCALE = 3'd2,
      OP_START_ONESHOT = 3'd3,
      OP_START_PERIOD  = 3'd4,
      OP_PAUSE         = 3'd5,
      OP_RESUME        = 3'd6,
      OP_STOP          = 3'd7
   } op_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   count_q, count_d;
   logic [WIDTH-1:0]   limit_q, limit_d;
   logic [PRE_W-1:0]   prescale_q, prescale_d;
   logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
   logic               oneshot_q, oneshot_d;
   logic               tick_q, tick_d;
   logic               ready_q, ready_d;

   logic accept;
   logic step_en;
   op_e  op;

   assign op     = op_e'(cmd_op);
   assign accept = cmd_valid && ready_q;

   // Register-only commands let the step proceed on the same edge, using the old limit/prescale.
   assign step_en = (state_q == ST_RUN) &&
                    (!accept || op == OP_NOP || op == OP_LOAD_LIMIT || op == OP_LOAD_PRESCALE);

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      state_d    = state_q;
      count_d    = count_q;
      limit_d    = limit_q;
      prescale_d = prescale_q;
      pre_cnt_d  = pre_cnt_q;
      oneshot_d  = oneshot_q;
      tick_d     = 1'b0;
      ready_d    = 1'b1;

      if (step_en) begin
         if (pre_cnt_q != prescale_q) begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
         end else begin
            pre_cnt_d = '0;
            if (count_q != limit_q) begin
               count_d = count_q + WIDTH'(1);
            end else begin
               tick_d = 1'b1;
               if (oneshot_q) state_d = ST_DONE;
               else           count_d = '0;
            end
         end
      end

      if (accept) begin
         ready_d = 1'b0;
         case (op)
            OP_LOAD_LIMIT:    limit_d    = cmd_data;
            OP_LOAD_PRESCALE: prescale_d = cmd_data[PRE_W-1:0];
            OP_START_ONESHOT, OP_START_PERIOD: begin
               count_d   = '0;
               pre_cnt_d = '0;
               oneshot_d = (op == OP_START_ONESHOT);
               state_d   = ST_RUN;
            end
            OP_PAUSE:  if (state_q == ST_RUN)   state_d = ST_PAUSE;
            OP_RESUME: if (state_q == ST_PAUSE) state_d = ST_RUN;
            OP_STOP: begin
               count_d   = '0;
               pre_cnt_d = '0;
               state_d   = ST_IDLE;
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         limit_q    <= '1;
         prescale_q <= '0;
         pre_cnt_q  <= '0;
         oneshot_q  <= 1'b0;
         tick_q     <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         limit_q    <= limit_d;
         prescale_q <= prescale_d;
         pre_cnt_q  <= pre_cnt_d;
         oneshot_q  <= oneshot_d;
         tick_q     <= tick_d;
         ready_q    <= ready_d;
      end
   end

   assign cmd_ready = ready_q;
   assign count     = count_q;
   assign state     = state_q;
   assign tick      = tick_q;
   assign busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: the driver queues hand-computed
// post-edge expectations, a negedge monitor pops and compares them.
module tb_counter_sequencer;

   localparam logic [2:0] NOP = 3'd0, LLIM = 3'd1, LPRE = 3'd2, SONE = 3'd3,
                          SPER = 3'd4, PAUSE = 3'd5, RESUME = 3'd6, STOP = 3'd7;
   localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

   logic       clk = 1'b0;
   logic       rst, cmd_valid, cmd_ready, tick, busy;
   logic [2:0] cmd_op;
   logic [7:0] cmd_data, count;
   logic [1:0] state;

   always #5 clk = ~clk;

   counter_sequencer #(.WIDTH(8), .PRE_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .count     (count),
      .state     (state),
      .tick      (tick),
      .busy      (busy)
   );

   typedef struct {
      string      name;
      logic [7:0] count;
      logic [1:0] state;
      logic       tick;
      logic       ready;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got {count,state,tick,ready,busy}=%h required %h", name, act, req);
      end
   endtask

   // Monitor: outputs are compared mid-cycle, well away from the active edge.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check(e.name, {count, state, tick, cmd_ready, busy},
               {e.count, e.state, e.tick, e.ready, e.state == S_RUN});
      end
   end

   task automatic cyc(input logic r, input logic v, input logic [2:0] op, input logic [7:0] d);
      rst = r; cmd_valid = v; cmd_op = op; cmd_data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, NOP, 8'h00);
   endtask

   task automatic expect_out(input string name, input logic [7:0] c, input logic [1:0] s,
                             input logic t, input logic r);
      exp_t e;
      e.name = name; e.count = c; e.state = s; e.tick = t; e.ready = r;
      sb.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_data = 8'h00;

      // 1: reset then idle, plus an illegal PAUSE from IDLE
      cyc(1'b1, 1'b0, NOP, 8'h00);
      expect_out("reset", 8'h00, S_IDLE, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         idle(); expect_out($sformatf("idle_%0d", i), 8'h00, S_IDLE, 1'b0, 1'b1);
      end
      cyc(1'b0, 1'b1, PAUSE, 8'h00); expect_out("pause_in_idle", 8'h00, S_IDLE, 1'b0, 1'b0);
      idle();                        expect_out("pause_in_idle_rdy", 8'h00, S_IDLE, 1'b0, 1'b1);

      // 2: one-shot, limit 3, prescale 0
      cyc(1'b0, 1'b1, LLIM, 8'd3);   expect_out("os_llim", 8'h00, S_IDLE, 1'b0, 1'b0);
      idle();                        expect_out("os_llim_rdy", 8'h00, S_IDLE, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, SONE, 8'h00);  expect_out("os_start", 8'h00, S_RUN, 1'b0, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         idle(); expect_out($sformatf("os_cnt_%0d", k), 8'(k), S_RUN, 1'b0, 1'b1);
      end
      idle(); expect_out("os_done_tick", 8'd3, S_DONE, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) begin
         idle(); expect_out($sformatf("os_hold_%0d", i), 8'd3, S_DONE, 1'b0, 1'b1);
      end

      // 3: periodic, prescale 2, limit 1 -> period 6
      cyc(1'b0, 1'b1, LPRE, 8'd2);   expect_out("per_lpre", 8'd3, S_DONE, 1'b0, 1'b0);
      idle();                        expect_out("per_lpre_rdy", 8'd3, S_DONE, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, LLIM, 8'd1);   expect_out("per_llim", 8'd3, S_DONE, 1'b0, 1'b0);
      idle();                        expect_out("per_llim_rdy", 8'd3, S_DONE, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, SPER, 8'h00);  expect_out("per_start", 8'h00, S_RUN, 1'b0, 1'b0);
      for (int k = 1; k <= 12; k++) begin
         idle();
         expect_out($sformatf("per_k%0d", k), (k % 6 >= 3) ? 8'd1 : 8'd0, S_RUN,
                    (k % 6 == 0), 1'b1);
      end

      // 4: pause/resume at count 0x10 with prescale 1, limit 0xFF
      cyc(1'b0, 1'b1, STOP, 8'h00);  expect_out("pr_stop", 8'h00, S_IDLE, 1'b0, 1'b0);
      idle();                        expect_out("pr_stop_rdy", 8'h00, S_IDLE, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, LPRE, 8'd1);   expect_out("pr_lpre", 8'h00, S_IDLE, 1'b0, 1'b0);
      idle();
      cyc(1'b0, 1'b1, LLIM, 8'hFF);  expect_out("pr_llim", 8'h00, S_IDLE, 1'b0, 1'b0);
      idle();
      cyc(1'b0, 1'b1, SPER, 8'h00);  expect_out("pr_start", 8'h00, S_RUN, 1'b0, 1'b0);
      for (int k = 1; k <= 32; k++) begin
         idle(); expect_out($sformatf("pr_run_%0d", k), 8'(k / 2), S_RUN, 1'b0, 1'b1);
      end
      cyc(1'b0, 1'b1, PAUSE, 8'h00); expect_out("pr_pause", 8'h10, S_PAUSE, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         idle(); expect_out($sformatf("pr_hold_%0d", i), 8'h10, S_PAUSE, 1'b0, 1'b1);
      end
      cyc(1'b0, 1'b1, RESUME, 8'h00); expect_out("pr_resume", 8'h10, S_RUN, 1'b0, 1'b0);
      idle();                         expect_out("pr_phase", 8'h10, S_RUN, 1'b0, 1'b1);
      idle();                         expect_out("pr_step", 8'h11, S_RUN, 1'b0, 1'b1);

      // Limit lowered below count in RUN: wraps through 0xFF to 0, then limit 0 ticks every 2 cycles
      cyc(1'b0, 1'b1, LLIM, 8'h00);  expect_out("wr_llim", 8'h11, S_RUN, 1'b0, 1'b0);
      for (int n = 1; n <= 477; n++) begin
         idle();
         if (n % 2 == 1)
            expect_out($sformatf("wr_%0d", n), 8'(8'h11 + (n + 1) / 2), S_RUN, 1'b0, 1'b1);
      end
      for (int n = 478; n <= 482; n++) begin
         idle(); expect_out($sformatf("lim0_%0d", n), 8'h00, S_RUN, (n % 2 == 1), 1'b1);
      end

      // 5: STOP on a terminal-step edge, second command held and accepted 2 cycles later
      cyc(1'b0, 1'b1, STOP, 8'h00);  expect_out("col_stop", 8'h00, S_IDLE, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, SPER, 8'h00);  expect_out("col_blocked", 8'h00, S_IDLE, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, SPER, 8'h00);  expect_out("col_accept", 8'h00, S_RUN, 1'b0, 1'b0);
      idle();                        expect_out("col_run", 8'h00, S_RUN, 1'b0, 1'b1);

      // 6: reset mid-run at count 0x42 with a START pending
      cyc(1'b0, 1'b1, STOP, 8'h00);  expect_out("rr_stop", 8'h00, S_IDLE, 1'b0, 1'b0);
      idle();
      cyc(1'b0, 1'b1, LPRE, 8'd0);   idle();
      cyc(1'b0, 1'b1, LLIM, 8'hFF);  idle();
      cyc(1'b0, 1'b1, SONE, 8'h00);  expect_out("rr_start", 8'h00, S_RUN, 1'b0, 1'b0);
      for (int k = 1; k <= 8'h42; k++) idle();
      expect_out("rr_at_42", 8'h42, S_RUN, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, SPER, 8'h00);  expect_out("rr_reset", 8'h00, S_IDLE, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         idle(); expect_out($sformatf("rr_after_%0d", i), 8'h00, S_IDLE, 1'b0, 1'b1);
      end

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) check("scoreboard_drain", 13'(sb.size()), 13'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller that owns and sequences the design's 8-bit event counter, replacing a bare free-running count.
- Accepts start/stop/pause/configure commands over a valid/ready interface and applies a prescaler.
- Runs in one-shot or periodic mode against a programmable limit, and emits a registered terminal-count tick.
- Sits between the pin-decoding logic (ui_in/uio_in) and the uo_out drive.

Parameters:
- WIDTH, 8: counter and limit width.
- PRE_W, 4: prescaler width; step every prescale+1 cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a clk edge.
- cmd_op  input  3  opcode, see Behaviour.
- cmd_data  input  WIDTH  operand; LOAD_PRESCALE uses [PRE_W-1:0].
- count  output  WIDTH  current counter value.
- state  output  2  0 IDLE, 1 RUN, 2 PAUSE, 3 DONE.
- tick  output  1  one-cycle pulse after a terminal-count step.
- busy  output  1  state==RUN (combinational from the state register).

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it is sampled at the clk edge and has priority over everything.
- Reset values: count=0, limit=all-ones, prescale=0, pre_cnt=0, mode=periodic, state=IDLE, tick=0, cmd_ready=1.
- Handshake:
  - cmd_ready is registered and does not depend on cmd_valid.
  - After any accepted command, cmd_ready=0 for exactly the next cycle, then 1. This allows at most one command per 2 cycles.
  - cmd_op/cmd_data are ignored when not accepted.
- Opcodes:
  - 0 NOP: no effect.
  - 1 LOAD_LIMIT: limit<=cmd_data. Legal in any state; in RUN it applies from the next step compare.
  - 2 LOAD_PRESCALE: prescale<=cmd_data[PRE_W-1:0]; pre_cnt is not cleared.
  - 3 START_ONESHOT / 4 START_PERIODIC: count<=0, pre_cnt<=0, mode set, state<=RUN. Legal from any state, including restart from RUN.
  - 5 PAUSE: RUN->PAUSE. count and pre_cnt are frozen.
  - 6 RESUME: PAUSE->RUN, continuing from the frozen count and pre_cnt.
  - 7 STOP: any state->IDLE, count<=0, pre_cnt<=0.
  - Commands illegal in the current state (PAUSE outside RUN, RESUME outside PAUSE) are accepted and ignored.
- Step, evaluated in RUN only, on each edge with no accepted command:
  - If pre_cnt!=prescale: pre_cnt++.
  - Otherwise pre_cnt<=0 and a step occurs:
    - count!=limit: count<=count+1.
    - count==limit, periodic: count<=0, tick<=1.
    - count==limit, one-shot: count holds at limit, state<=DONE, tick<=1.
- Period: (limit+1)*(prescale+1) cycles.
- Wrap: count never passes limit. If LOAD_LIMIT sets a limit below the current count, count keeps incrementing modulo 2^WIDTH until it equals limit. Arithmetic is modulo 2^WIDTH.
- limit=0: every step is terminal. Periodic mode gives count stuck at 0 with tick every prescale+1 cycles.
- Simultaneous command and step edge: the command wins and the step is suppressed for that edge. pre_cnt does not advance, except LOAD_LIMIT/LOAD_PRESCALE/NOP in RUN, where the step proceeds using the old limit/prescale.
- tick is 0 in every cycle not immediately following a terminal step.
- DONE persists until START or STOP.
- Reset mid-operation: all registers return to reset values on the edge where rst=1, regardless of state or pending command.

Test Plan:
1. Reset then idle: rst=1 one cycle -> count=0, state=0, tick=0, cmd_ready=1, busy=0; no change for 20 idle cycles.
2. One-shot, prescale 0: LOAD_LIMIT 3, then START_ONESHOT accepted at edge T -> count 1,2,3 after edges T+1..T+3; at T+4 state=DONE, count=3, tick=1 for one cycle; count stays 3 for 10 more cycles.
3. Periodic with prescale: LOAD_PRESCALE 2, LOAD_LIMIT 1, START_PERIODIC -> count 0,0,0,1,1,1,0 pattern; tick pulses every 6 cycles; cmd_ready low for exactly 1 cycle after each command.
4. Pause/resume: during periodic limit 0xFF at count=0x10 issue PAUSE -> count held 0x10 for 8 cycles with busy=0; RESUME -> next step gives 0x11 at the expected pre_cnt phase.
5. Back-to-back and collision: cmd_valid held high with STOP on the cycle a terminal step would occur -> STOP wins, tick stays 0, count=0; a second command presented immediately is accepted 2 cycles after the first.
6. Reset mid-run: rst=1 while RUN count=0x42 with cmd_valid=1 (START) -> next cycle all reset values; the command is not executed.
